frame_update_sched: RTL

//  Per-frame scheduler for the air-hockey game logic in the VGA pipeline (800x600 visible, 1056x628 total).
//  On each vertical-blanking entry it runs a fixed chain of game-logic stages one at a time.
//  The chain is mallet read, puck physics, collision, score; each stage uses a start/done handshake.

---
 rtl/frame_update_sched.sv | 127 ++++++++++++
 1 files changed

// File: rtl/frame_update_sched.sv
// Per-frame game-logic scheduler: on vblank entry it runs a chain of stages via start/done
// handshakes, then pulses frame_commit; a stage timeout or early vblank end aborts the frame.
module frame_update_sched #(
  parameter int N_STAGES  = 4,
  parameter int TIMEOUT   = 20000,
  parameter int FRAME_DIV = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                vblnk_i,
  input  logic [N_STAGES-1:0] stage_done_i,
  input  logic                overrun_clr_i,
  output logic [N_STAGES-1:0] stage_start_o,
  output logic                frame_commit_o,
  output logic                busy_o,
  output logic                overrun_o,
  output logic [7:0]          overrun_cnt_o,
  output logic [15:0]         frame_cnt_o
);

  localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);
  localparam logic [15:0]      TMAX     = 16'(TIMEOUT - 1);
  localparam logic [3:0]       DIV_LAST = 4'(FRAME_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, COMMIT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      timer_q, timer_d;
  logic [3:0]       div_q, div_d;
  logic             vblnk_q;
  logic             overrun_q, overrun_d;
  logic [7:0]       ocnt_q, ocnt_d;
  logic [15:0]      fcnt_q, fcnt_d;

  logic                rise, fall, done_sel;
  logic [N_STAGES-1:0] done_hit;

  assign rise = vblnk_i & ~vblnk_q;
  assign fall = ~vblnk_i & vblnk_q;

  // Only the done bit of the stage currently being waited on is honoured.
  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
    assign stage_start_o[gi] = (state_q == START) && (idx_q == IDX_W'(gi));
    assign done_hit[gi]      = stage_done_i[gi] && (idx_q == IDX_W'(gi));
  end
  assign done_sel = |done_hit;

  assign frame_commit_o = (state_q == COMMIT);
  assign busy_o         = (state_q != IDLE);
  assign overrun_o      = overrun_q;
  assign overrun_cnt_o  = ocnt_q;
  assign frame_cnt_o    = fcnt_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    div_d     = div_q;
    overrun_d = overrun_clr_i ? 1'b0 : overrun_q;
    ocnt_d    = ocnt_q;
    fcnt_d    = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (rise && en_i) begin
          if (div_q == DIV_LAST) begin
            div_d   = 4'd0;
            idx_d   = '0;
            state_d = START;
          end else begin
            div_d = div_q + 4'd1;
          end
        end
      end
      START: begin
        timer_d = 16'd0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 16'd1;
        if (done_sel) begin
          if (idx_q == LAST_IDX) begin
            state_d = COMMIT;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = START;
          end
        end else if (fall || timer_q == TMAX) begin
          // Abort beats a same-cycle overrun_clr.
          overrun_d = 1'b1;
          if (ocnt_q != 8'hFF) ocnt_d = ocnt_q + 8'd1;
          state_d = IDLE;
        end
      end
      COMMIT: begin
        fcnt_d  = fcnt_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      timer_q   <= 16'd0;
      div_q     <= 4'd0;
      vblnk_q   <= 1'b0;
      overrun_q <= 1'b0;
      ocnt_q    <= 8'd0;
      fcnt_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      div_q     <= div_d;
      vblnk_q   <= vblnk_i;
      overrun_q <= overrun_d;
      ocnt_q    <= ocnt_d;
      fcnt_q    <= fcnt_d;
    end
  end

endmodule
